// File: rtl/uart_cmd_sequencer_pkg.sv
// Package for the UART command sequencer.
// Holds the FSM state type, the frame opcodes, the response codes and the
// register data width shared by the interface, the top and the testbench.
package uart_cmd_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StRegWr,
        StRegRd,
        StWaitRd,
        StSendResp
    } state_e;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Bus interface of the UART command sequencer.
// Groups the RX FIFO pop side, the TX FIFO push side and the register port.
//   master : the sequencer (pops RX, pushes TX, issues register strobes)
//   slave  : the environment (FIFOs and register file)
interface uart_cmd_sequencer_if;
    import uart_cmd_pkg::*;

    // RX byte FIFO
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_rd_en;
    // TX byte FIFO
    logic              tx_full;
    logic              tx_wr_en;
    logic [7:0]        tx_wr_data;
    // Register port
    logic [7:0]        reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [DATA_W-1:0] reg_rdata;
    logic              reg_rd_valid;

    modport master (
        input  rx_valid, rx_data, tx_full, reg_rdata, reg_rd_valid,
        output rx_rd_en, tx_wr_en, tx_wr_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en
    );

    modport slave (
        output rx_valid, rx_data, tx_full, reg_rdata, reg_rd_valid,
        input  rx_rd_en, tx_wr_en, tx_wr_data, reg_addr, reg_wdata, reg_wr_en, reg_rd_en
    );

endinterface

// File: rtl/uart_cmd_sequencer_timeout.sv
// Clear/enable/expire counter used to abort stalled frames and reads.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : forces the count to zero (takes priority over enable)
//   enable     : counts one per cycle while high
//   limit      : count value at which expired is raised
//   expired    : high while enabled, not cleared and the count equals limit
module cmd_timeout_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        expired = enable && !clear && (count_q == limit);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer.
// Decodes byte frames popped from an RX FIFO into register writes/reads and
// pushes response bytes (ACK, NAK or 4 read-data bytes MSB first) to a TX FIFO.
//   write frame: 0x57, addr, d3, d2, d1, d0  -> reg write, response ACK
//   read  frame: 0x52, addr                  -> reg read,  response d3..d0
//   bad opcode or inter-byte / read timeout  -> response NAK, no strobe
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : RX/TX FIFO and register port (master side)
//   busy       : high whenever the FSM is not idle
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned RD_LATENCY_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_cmd_sequencer_if.master  bus,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] ByteLimit = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] RdLimit   = CntW'(RD_LATENCY_MAX);

    state_e            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic [1:0]        resp_cnt_q, resp_cnt_d;

    logic            pop;
    logic            tmo_clear;
    logic            tmo_enable;
    logic [CntW-1:0] tmo_limit;
    logic            tmo_expired;

    // Pop only in the frame-receiving states; gated by reset so the FIFO is
    // never drained while the block is held in reset.
    assign pop = rst_n && bus.rx_valid && (state_q inside {StIdle, StGetAddr, StGetData});

    // Clearing in REG_RD makes the first WAIT_RD cycle start at zero.
    assign tmo_clear  = pop || (state_q == StRegRd);
    assign tmo_enable = state_q inside {StGetAddr, StGetData, StWaitRd};
    assign tmo_limit  = (state_q == StWaitRd) ? RdLimit : ByteLimit;

    cmd_timeout_counter #(
        .WIDTH (CntW)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .limit   (tmo_limit),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        byte_cnt_d = byte_cnt_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                        is_write_d = (bus.rx_data == OP_WRITE);
                        state_d    = StGetAddr;
                    end else begin
                        resp_d     = {NAK, 24'h0};
                        resp_cnt_d = 2'd0;
                        state_d    = StSendResp;
                    end
                end
            end
            StGetAddr: begin
                if (pop) begin
                    addr_d     = bus.rx_data;
                    byte_cnt_d = 2'd0;
                    state_d    = is_write_q ? StGetData : StRegRd;
                end else if (tmo_expired) begin
                    resp_d     = {NAK, 24'h0};
                    resp_cnt_d = 2'd0;
                    state_d    = StSendResp;
                end
            end
            StGetData: begin
                if (pop) begin
                    wdata_d    = {wdata_q[DATA_W-9:0], bus.rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StRegWr;
                    end
                end else if (tmo_expired) begin
                    resp_d     = {NAK, 24'h0};
                    resp_cnt_d = 2'd0;
                    state_d    = StSendResp;
                end
            end
            StRegWr: begin
                resp_d     = {ACK, 24'h0};
                resp_cnt_d = 2'd0;
                state_d    = StSendResp;
            end
            StRegRd: begin
                state_d = StWaitRd;
            end
            StWaitRd: begin
                if (bus.reg_rd_valid) begin
                    resp_d     = bus.reg_rdata;
                    resp_cnt_d = 2'd3;
                    state_d    = StSendResp;
                end else if (tmo_expired) begin
                    resp_d     = {NAK, 24'h0};
                    resp_cnt_d = 2'd0;
                    state_d    = StSendResp;
                end
            end
            StSendResp: begin
                // Head byte stays in resp_q[31:24] until the FIFO accepts it.
                if (!bus.tx_full) begin
                    resp_d = resp_q << 8;
                    if (resp_cnt_q == 2'd0) begin
                        state_d = StIdle;
                    end else begin
                        resp_cnt_d = resp_cnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.rx_rd_en   = pop;
        bus.tx_wr_en   = (state_q == StSendResp) && !bus.tx_full;
        bus.tx_wr_data = (state_q == StSendResp) ? resp_q[DATA_W-1:DATA_W-8] : 8'h00;
        bus.reg_addr   = addr_q;
        bus.reg_wdata  = wdata_q;
        bus.reg_wr_en  = (state_q == StRegWr);
        bus.reg_rd_en  = (state_q == StRegRd);
        busy           = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            byte_cnt_q <= '0;
            resp_q     <= '0;
            resp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            byte_cnt_q <= byte_cnt_d;
            resp_q     <= resp_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

endmodule
